// File: rtl/regfile_pkg.sv
// Shared register-file constants used by regfile_sb and by the decode and hazard units.
package regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_CNT_W  = 2;

   // Hard-wired zero register when ZERO_REG is enabled.
   localparam logic [RF_ADDR_W-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one register, with flush clear and
// per-cycle overflow/underflow strobes.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A clear discards same-cycle counts, so it also suppresses the error strobes.
   always_comb begin
      cnt_d = cnt_q;
      ovf_o = 1'b0;
      unf_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (cnt_q == CNT_MAX) ovf_o = 1'b1;
         else                  cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) unf_o = 1'b1;
         else             cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending-write scoreboard that flags RAW hazards the bypass cannot cover.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int CNT_W    = RF_CNT_W,
   parameter int ZERO_REG = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     WE,
   input  logic [ADDR_W-1:0]        WADDR,
   input  logic [DATA_W-1:0]        WDATA,
   input  logic [NUM_RD*ADDR_W-1:0] RADDR,
   output logic [NUM_RD*DATA_W-1:0] RDATA,
   output logic [NUM_RD-1:0]        RBUSY,
   input  logic                     ISSUE,
   input  logic [ADDR_W-1:0]        ISSUE_ADDR,
   input  logic                     FLUSH,
   output logic                     SB_ERR
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  cnt   [DEPTH];
   logic [DEPTH-1:0]  ovf_v;
   logic [DEPTH-1:0]  unf_v;
   logic              err_q;
   logic              err_d;
   logic              we_eff;
   logic              issue_eff;

   // Accesses to the hard-wired zero register are dropped before storage and scoreboard.
   assign we_eff    = WE    && !(ZERO_REG != 0 && WADDR      == ADDR_W'(ZERO_ADDR));
   assign issue_eff = ISSUE && !(ZERO_REG != 0 && ISSUE_ADDR == ADDR_W'(ZERO_ADDR));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else if (we_eff) begin
         mem_q[WADDR] <= WDATA;
      end
   end

   for (genvar j = 0; j < DEPTH; j++) begin : g_sb
      logic inc;
      logic dec;
      logic same;

      // Issue and writeback to the same register in one cycle cancel out.
      assign same = issue_eff && we_eff && (ISSUE_ADDR == WADDR);
      assign inc  = issue_eff && (ISSUE_ADDR == ADDR_W'(j)) && !same;
      assign dec  = we_eff    && (WADDR      == ADDR_W'(j)) && !same;

      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .CLK   (CLK),
         .RST   (RST),
         .inc_i (inc),
         .dec_i (dec),
         .clr_i (FLUSH),
         .cnt_o (cnt[j]),
         .ovf_o (ovf_v[j]),
         .unf_o (unf_v[j])
      );
   end

   assign err_d = err_q || (|ovf_v) || (|unf_v);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign SB_ERR = err_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              is_zero;
      logic              byp;
      logic [CNT_W-1:0]  rcnt;

      assign ra      = RADDR[i*ADDR_W +: ADDR_W];
      assign is_zero = (ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR));
      assign byp     = we_eff && (WADDR == ra);
      assign rcnt    = cnt[ra];

      assign RDATA[i*DATA_W +: DATA_W] = is_zero ? '0 : (byp ? WDATA : mem_q[ra]);

      // The last outstanding write landing this cycle is covered by the bypass.
      assign RBUSY[i] = !is_zero && (rcnt != '0) && !(byp && rcnt == CNT_W'(1));
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: array/integer reference model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_regfile_sb;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        WE = 1'b0;
   logic [4:0]  WADDR = '0;
   logic [31:0] WDATA = '0;
   logic [4:0]  ra0 = '0;
   logic [4:0]  ra1 = '0;
   logic [9:0]  RADDR;
   logic [63:0] RDATA;
   logic [1:0]  RBUSY;
   logic        ISSUE = 1'b0;
   logic [4:0]  ISSUE_ADDR = '0;
   logic        FLUSH = 1'b0;
   logic        SB_ERR;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_reg [32];
   int          m_cnt [32];
   logic        m_err;

   assign RADDR = {ra1, ra0};

   regfile_sb dut (
      .CLK        (CLK),
      .RST        (RST),
      .WE         (WE),
      .WADDR      (WADDR),
      .WDATA      (WDATA),
      .RADDR      (RADDR),
      .RDATA      (RDATA),
      .RBUSY      (RBUSY),
      .ISSUE      (ISSUE),
      .ISSUE_ADDR (ISSUE_ADDR),
      .FLUSH      (FLUSH),
      .SB_ERR     (SB_ERR)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // reference model: architectural state after each edge
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < 32; k++) begin
            m_reg[k] <= '0;
            m_cnt[k] <= 0;
         end
         m_err <= 1'b0;
      end else begin
         if (WE && WADDR != 0) m_reg[WADDR] <= WDATA;
         if (FLUSH) begin
            for (int k = 0; k < 32; k++) m_cnt[k] <= 0;
         end else begin
            if (ISSUE && ISSUE_ADDR != 0 && !(WE && WADDR == ISSUE_ADDR)) begin
               if (m_cnt[ISSUE_ADDR] == 3) m_err <= 1'b1;
               else m_cnt[ISSUE_ADDR] <= m_cnt[ISSUE_ADDR] + 1;
            end
            if (WE && WADDR != 0 && !(ISSUE && ISSUE_ADDR == WADDR)) begin
               if (m_cnt[WADDR] == 0) m_err <= 1'b1;
               else m_cnt[WADDR] <= m_cnt[WADDR] - 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle compare of outputs against the model
   always @(negedge CLK) begin
      if (!RST) begin
         for (int p = 0; p < 2; p++) begin
            logic [4:0]  a;
            logic [31:0] ed;
            logic        eb;
            a  = (p == 0) ? ra0 : ra1;
            if (a == 0)                  ed = '0;
            else if (WE && WADDR == a)   ed = WDATA;
            else                         ed = m_reg[a];
            eb = (a != 0) && (m_cnt[a] != 0) && !(WE && WADDR == a && m_cnt[a] == 1);
            check($sformatf("model_rdata%0d", p), RDATA[p*32 +: 32], ed);
            check($sformatf("model_rbusy%0d", p), {31'b0, RBUSY[p]}, {31'b0, eb});
         end
         check("model_sb_err", {31'b0, SB_ERR}, {31'b0, m_err});
      end
   end

   // driver tasks
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic is, input logic [4:0] ia, input logic fl,
                        input logic [4:0] r0, input logic [4:0] r1);
      WE = we; WADDR = wa; WDATA = wd;
      ISSUE = is; ISSUE_ADDR = ia; FLUSH = fl;
      ra0 = r0; ra1 = r1;
      #2;
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, r0, r1);
   endtask

   initial begin
      // reset state
      #1;
      check("rst_rdata0", RDATA[31:0], 32'h0);
      check("rst_rbusy", {30'b0, RBUSY}, 32'h0);
      check("rst_sb_err", {31'b0, SB_ERR}, 32'h0);
      step(); step();
      RST = 1'b0;

      // scenario 1: populate r5, create busy + error, then async reset mid-cycle
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0); step();
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0); step();
      drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0); step();
      idle(5'd5, 5'd2);
      check("s1_r5", RDATA[31:0], 32'hDEAD_BEEF);
      check("s1_r5_busy", {31'b0, RBUSY[0]}, 32'h1);
      check("s1_underflow_err", {31'b0, SB_ERR}, 32'h1);
      check("s1_r2_written", RDATA[63:32], 32'h2222);
      RST = 1'b1;
      #1;
      check("s1_rst_r5", RDATA[31:0], 32'h0);
      check("s1_rst_busy", {30'b0, RBUSY}, 32'h0);
      check("s1_rst_err", {31'b0, SB_ERR}, 32'h0);
      step();
      RST = 1'b0;

      // scenario 2: write-through bypass and r0 writes
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0); step();
      drive(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
      check("s2_bypass0", RDATA[31:0], 32'h1234);
      check("s2_bypass1", RDATA[63:32], 32'h1234);
      check("s2_bypass_notbusy", {31'b0, RBUSY[0]}, 32'h0);
      step();
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
      check("s2_r0_write_read", RDATA[63:32], 32'h0);
      step();
      idle(5'd7, 5'd0);
      check("s2_r7_stored", RDATA[31:0], 32'h1234);
      check("s2_r0_still_zero", RDATA[63:32], 32'h0);
      check("s2_no_err", {31'b0, SB_ERR}, 32'h0);

      // scenario 3: two issues to r3, resolved by two writes
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0); step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0); step();
      idle(5'd3, 5'd3);
      check("s3_busy_after_2_issue", {30'b0, RBUSY}, 32'h3);
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      check("s3_busy_first_we", {31'b0, RBUSY[0]}, 32'h1);
      step();
      drive(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      check("s3_free_second_we", {31'b0, RBUSY[0]}, 32'h0);
      check("s3_bypass_data", RDATA[31:0], 32'h34);
      step();
      idle(5'd3, 5'd0);
      check("s3_free_after", {31'b0, RBUSY[0]}, 32'h0);
      check("s3_data_after", RDATA[31:0], 32'h34);

      // scenario 4: same-cycle issue and write to r4 with one pending
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0); step();
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0); step();
      idle(5'd4, 5'd0);
      check("s4_busy_kept", {31'b0, RBUSY[0]}, 32'h1);
      check("s4_data_written", RDATA[31:0], 32'h44);

      // scenario 6: flush with r3, r4 pending, same-cycle issue r6 and write r4
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4); step();
      drive(1'b1, 5'd4, 32'h4444_0000, 1'b1, 5'd6, 1'b1, 5'd3, 5'd4);
      check("s6_busy_before_flush", {31'b0, RBUSY[0]}, 32'h1);
      step();
      idle(5'd3, 5'd4);
      check("s6_all_free", {30'b0, RBUSY}, 32'h0);
      check("s6_r3_kept", RDATA[31:0], 32'h34);
      check("s6_r4_flush_write", RDATA[63:32], 32'h4444_0000);
      idle(5'd6, 5'd0);
      check("s6_r6_free", {31'b0, RBUSY[0]}, 32'h0);
      check("s6_no_err", {31'b0, SB_ERR}, 32'h0);

      // scenario 5: overflow on r9, then write without issue on r10
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0); step();
      end
      idle(5'd9, 5'd0);
      check("s5_busy_at_max", {31'b0, RBUSY[0]}, 32'h1);
      check("s5_no_err_at_max", {31'b0, SB_ERR}, 32'h0);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0); step();
      idle(5'd9, 5'd0);
      check("s5_overflow_err", {31'b0, SB_ERR}, 32'h1);
      // saturated at 3: three writes needed, the third resolved by bypass
      drive(1'b1, 5'd9, 32'h91, 1'b1, 5'd11, 1'b0, 5'd9, 5'd11); step();
      drive(1'b1, 5'd9, 32'h92, 1'b0, 5'd0, 1'b0, 5'd9, 5'd11); step();
      drive(1'b1, 5'd9, 32'h93, 1'b0, 5'd0, 1'b0, 5'd9, 5'd11);
      check("s5_r9_last_free", {31'b0, RBUSY[0]}, 32'h0);
      check("s5_r11_busy", {31'b0, RBUSY[1]}, 32'h1);
      step();
      drive(1'b1, 5'd10, 32'hA0A0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd9); step();
      idle(5'd10, 5'd9);
      check("s5_r10_written", RDATA[31:0], 32'hA0A0);
      check("s5_r9_final", RDATA[63:32], 32'h93);
      check("s5_err_sticky", {31'b0, SB_ERR}, 32'h1);
      step(); step();
      check("s5_err_still", {31'b0, SB_ERR}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
